// File: rtl/flash_arb_pkg.sv
// Shared types for the two-master QSPI flash bus arbiter.
// The optional forced-revoke timer is enabled by defining FLASH_ARB_TIMEOUT_EN.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_RELEASE
  } arb_state_t;

  typedef logic midx_t;

  // Guard counter holds N_GUARD-1, so N_GUARD may be at most 2**GUARD_W.
  localparam int GUARD_W   = 8;
  localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, and a tie goes to the
// master that was not served last.
module flash_arb_rr
  import flash_arb_pkg::*;
(
  input  logic [1:0] req,
  input  midx_t      last_served,
  output midx_t      winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last_served : req[1];
  end

endmodule

// File: rtl/flash_bus_arbiter.sv
// Shares one QSPI flash pin set between two masters at transaction granularity.
// Define FLASH_ARB_TIMEOUT_EN to add the forced-revoke timer and the per-master lockout.
//
//   state      | meaning
//   ST_IDLE    | pins idle, nothing granted, pick the next owner
//   ST_OWN     | gnt held, owner's drives registered onto the flash pins
//   ST_RELEASE | nCE-high guard gap, N_GUARD cycles, selected still 1
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int N_GUARD = 2
`ifdef FLASH_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  output logic       m0_gnt,
  input  logic       m0_nce,
  input  logic       m0_sclk,
  input  logic [3:0] m0_sout,
  input  logic       m0_oe,
  input  logic       m0_qpi,
  output logic [3:0] m0_sin,
  input  logic       m1_req,
  output logic       m1_gnt,
  input  logic       m1_nce,
  input  logic       m1_sclk,
  input  logic [3:0] m1_sout,
  input  logic       m1_oe,
  input  logic       m1_qpi,
  output logic [3:0] m1_sin,
  output logic       flash_nce,
  output logic       flash_sclk,
  output logic [3:0] flash_sout,
  output logic       flash_oe,
  output logic       flash_bus_qpi,
  input  logic [3:0] flash_sin,
  output logic       flash_selected,
  output logic       arb_timeout,
  output logic       arb_violation
);

  arb_state_t         state;
  midx_t              owner;
  midx_t              last_served;
  midx_t              pick;
  logic               pick_valid;
  logic [GUARD_W-1:0] guard_cnt;
  logic [1:0]         req_v;
  logic [1:0]         req_eff;
  logic               timeout_hit;
  logic               timeout_pulse;

  logic       own_req;
  logic       own_nce;
  logic       own_sclk;
  logic [3:0] own_sout;
  logic       own_oe;
  logic       own_qpi;

  assign m0_sin      = flash_sin;
  assign m1_sin      = flash_sin;
  assign req_v       = {m1_req, m0_req};
  assign arb_timeout = timeout_pulse;

  always_comb begin
    own_req  = owner ? m1_req  : m0_req;
    own_nce  = owner ? m1_nce  : m0_nce;
    own_sclk = owner ? m1_sclk : m0_sclk;
    own_sout = owner ? m1_sout : m0_sout;
    own_oe   = owner ? m1_oe   : m0_oe;
    own_qpi  = owner ? m1_qpi  : m0_qpi;
  end

`ifdef FLASH_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] own_cnt;
  logic [1:0]           lockout;

  assign timeout_hit = (state == ST_OWN) && own_req &&
                       (own_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));
  assign req_eff     = req_v & ~lockout;

  // A revoked master stays locked out until its req has been seen low once.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_cnt <= '0;
      lockout <= '0;
    end else begin
      own_cnt <= (state == ST_OWN) ? own_cnt + 1'b1 : '0;
      lockout <= lockout & req_v;
      if (timeout_hit)
        lockout[owner] <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign req_eff     = req_v;
`endif

  flash_arb_rr u_rr (
    .req         (req_eff),
    .last_served (last_served),
    .winner      (pick),
    .valid       (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      owner          <= 1'b0;
      last_served    <= 1'b1;
      guard_cnt      <= '0;
      m0_gnt         <= 1'b0;
      m1_gnt         <= 1'b0;
      flash_nce      <= 1'b1;
      flash_sclk     <= 1'b0;
      flash_sout     <= 4'h0;
      flash_oe       <= 1'b0;
      flash_bus_qpi  <= 1'b0;
      flash_selected <= 1'b0;
      arb_violation  <= 1'b0;
      timeout_pulse  <= 1'b0;
    end else begin
      // Pins rest idle unless an active owner overrides them below.
      flash_nce     <= 1'b1;
      flash_sclk    <= 1'b0;
      flash_sout    <= 4'h0;
      flash_oe      <= 1'b0;
      flash_bus_qpi <= 1'b0;
      arb_violation <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner          <= pick;
            last_served    <= pick;
            m0_gnt         <= ~pick;
            m1_gnt         <= pick;
            flash_selected <= 1'b1;
            state          <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!own_req || timeout_hit) begin
            m0_gnt        <= 1'b0;
            m1_gnt        <= 1'b0;
            guard_cnt     <= GUARD_W'(N_GUARD - 1);
            arb_violation <= !own_req && !own_nce;
            timeout_pulse <= timeout_hit;
            state         <= ST_RELEASE;
          end else begin
            flash_nce     <= own_nce;
            flash_sclk    <= own_sclk;
            flash_sout    <= own_sout;
            flash_oe      <= own_oe;
            flash_bus_qpi <= own_qpi;
          end
        end
        ST_RELEASE: begin
          if (guard_cnt == '0) begin
            flash_selected <= 1'b0;
            state          <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
